// File: rtl/comparator_bist_if.sv
// +--------------------------------------------------------------------+
// | comparator_bist_if : operand/flag bus between BIST and comparator  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface comparator_bist_if;
  logic [1:0] dut_a;
  logic [1:0] dut_b;
  logic       dut_lt;
  logic       dut_eq;
  logic       dut_gt;

  modport master (
    output dut_a,
    output dut_b,
    input  dut_lt,
    input  dut_eq,
    input  dut_gt
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    output dut_lt,
    output dut_eq,
    output dut_gt
  );
endinterface

`default_nettype wire

// File: rtl/comparator_bist.sv
// +--------------------------------------------------------------------+
// | comparator_bist : exhaustive 2-bit comparator self-test engine     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module comparator_bist #(
  parameter int SETTLE = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  comparator_bist_if.master      cmp,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [4:0]             err_count,
  output logic                   fail_seen,
  output logic [3:0]             first_fail
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] c_settle_last = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);
  localparam logic       c_no_settle   = (SETTLE == 0);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_v;
  logic [2:0] r_wait_cnt;
  logic [4:0] r_err_count;
  logic       r_fail_seen;
  logic [3:0] r_first_fail;
  logic       r_pass;

  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [2:0] w_exp;
  logic [2:0] w_got;
  logic       w_fail;
  logic       w_start_ok;
  logic       w_last_vec;
  logic [4:0] w_err_nxt;

  assign w_a        = r_v[3:2];
  assign w_b        = r_v[1:0];
  assign w_exp      = {(w_a < w_b), (w_a == w_b), (w_a > w_b)};
  assign w_got      = {cmp.dut_lt, cmp.dut_eq, cmp.dut_gt};
  // Exact 3-bit match: multi-hot and all-zero flag patterns count as failures.
  assign w_fail     = (w_got != w_exp);
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_vec = (r_v == 4'd15);
  assign w_err_nxt  = r_err_count + {4'd0, w_fail};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_state_nxt = c_no_settle ? ST_CHECK : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == c_settle_last) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_state_nxt = w_last_vec ? ST_DONE : ST_APPLY;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v          <= 4'd0;
      r_wait_cnt   <= 3'd0;
      r_err_count  <= 5'd0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= 4'd0;
      r_pass       <= 1'b0;
    end else if (w_start_ok) begin
      r_v          <= 4'd0;
      r_wait_cnt   <= 3'd0;
      r_err_count  <= 5'd0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= 4'd0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        ST_APPLY: begin
          r_wait_cnt <= 3'd0;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 3'd1;
        end
        ST_CHECK: begin
          if (w_fail) begin
            r_err_count <= w_err_nxt;
            if (!r_fail_seen) begin
              r_fail_seen  <= 1'b1;
              r_first_fail <= r_v;
            end
          end
          // The final vector stays on the operand bus while DONE is held.
          if (w_last_vec) begin
            r_pass <= (w_err_nxt == 5'd0);
          end else begin
            r_v <= r_v + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmp.dut_a  = w_a;
  assign cmp.dut_b  = w_b;
  assign busy       = (r_state == ST_APPLY) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
  assign done       = (r_state == ST_DONE);
  assign pass       = r_pass && done;
  assign err_count  = r_err_count;
  assign fail_seen  = r_fail_seen;
  assign first_fail = r_first_fail;

endmodule

`default_nettype wire
